// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: funct3 size encodings, FSM states,
// byte-enable patterns and the funct3 size decoder.
package mem_stage_pkg;

  localparam logic [2:0] Funct3Lb  = 3'b000;
  localparam logic [2:0] Funct3Lh  = 3'b001;
  localparam logic [2:0] Funct3Lw  = 3'b010;
  localparam logic [2:0] Funct3Lbu = 3'b100;
  localparam logic [2:0] Funct3Lhu = 3'b101;

  typedef enum logic [1:0] {SizeByte, SizeHalf, SizeWord} mem_size_e;

  typedef logic [1:0] mem_state_t;
  localparam mem_state_t StIdle = 2'd0;
  localparam mem_state_t StReq  = 2'd1;
  localparam mem_state_t StWait = 2'd2;
  localparam mem_state_t StDone = 2'd3;

  localparam logic [3:0] BeByte   = 4'b0001;
  localparam logic [3:0] BeHalfLo = 4'b0011;
  localparam logic [3:0] BeHalfHi = 4'b1100;
  localparam logic [3:0] BeWord   = 4'b1111;

  // Undefined encodings fall through to a full-word access.
  function automatic mem_size_e funct3_size(input logic [2:0] funct3);
    case (funct3)
      Funct3Lb, Funct3Lbu: return SizeByte;
      Funct3Lh, Funct3Lhu: return SizeHalf;
      default:             return SizeWord;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data aligner: selects the addressed byte/half lane of a read word and
// sign- or zero-extends it according to funct3.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        sext;

  always_comb begin
    case (lane_i)
      2'd0:    byte_v = rdata_i[7:0];
      2'd1:    byte_v = rdata_i[15:8];
      2'd2:    byte_v = rdata_i[23:16];
      default: byte_v = rdata_i[31:24];
    endcase
    half_v = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    sext   = ~funct3_i[2];
    case (funct3_size(funct3_i))
      SizeByte: result_o = {{24{sext & byte_v[7]}}, byte_v};
      SizeHalf: result_o = {{16{sext & half_v[15]}}, half_v};
      default:  result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: drives a req/gnt/rvalid data port for loads/stores,
// stalls upstream while busy, passes non-memory results through in one cycle.
// Optional MEM_MISALIGN_CHECK_EN flags misaligned H/W accesses instead of aligning them.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ex_mem_valid_inst_i,
  input  logic [31:0] ex_mem_alu_result_i,
  input  logic [31:0] ex_mem_regb_i,
  input  logic        ex_mem_rd_mem_i,
  input  logic        ex_mem_wr_mem_i,
  input  logic [2:0]  ex_mem_funct3_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        mem_stall_o,
  output logic        mem_valid_o,
  output logic [31:0] mem_result_o,
  output logic        mem_bus_err_o,
  output logic        mem_misaligned_o
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutEn ? TIMEOUT_CYCLES - 1 : 0);

  mem_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [29:0]     word_addr_q, word_addr_d;
  logic [31:0]     regb_q, regb_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      lane_q, lane_d;
  logic            load_q, load_d;
  logic            rsp_pend_q, rsp_pend_d;
  logic            valid_q, valid_d;
  logic [31:0]     result_q, result_d;
  logic            bus_err_q, bus_err_d;
  logic            misaligned_q, misaligned_d;

  logic        mem_op;
  mem_size_e   size_in, size_q;
  logic [1:0]  lane_in;
  logic        misalign_in;
  logic        timeout_hit;
  logic [31:0] load_data;

  assign mem_op      = ex_mem_valid_inst_i & (ex_mem_rd_mem_i | ex_mem_wr_mem_i);
  assign size_in     = funct3_size(ex_mem_funct3_i);
  assign size_q      = funct3_size(funct3_q);
  assign timeout_hit = TimeoutEn && (cnt_q == CntLast);

  // Lane is forced to natural alignment; without the check this is the only handling.
  always_comb begin
    case (size_in)
      SizeByte: lane_in = ex_mem_alu_result_i[1:0];
      SizeHalf: lane_in = {ex_mem_alu_result_i[1], 1'b0};
      default:  lane_in = 2'b00;
    endcase
  end

`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign_in = ((size_in == SizeHalf) && ex_mem_alu_result_i[0]) ||
                       ((size_in == SizeWord) && (ex_mem_alu_result_i[1:0] != 2'b00));
`else
  assign misalign_in = 1'b0;
`endif

  mem_load_align u_load_align (
    .rdata_i  (dmem_rdata_i),
    .lane_i   (lane_q),
    .funct3_i (funct3_q),
    .result_o (load_data)
  );

  always_comb begin
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = '0;
    dmem_wdata_o = '0;
    dmem_be_o    = '0;
    if (state_q == StReq) begin
      dmem_req_o  = 1'b1;
      dmem_we_o   = ~load_q;
      dmem_addr_o = {word_addr_q, 2'b00};
      case (size_q)
        SizeByte: begin
          dmem_be_o    = BeByte << lane_q;
          dmem_wdata_o = {4{regb_q[7:0]}};
        end
        SizeHalf: begin
          dmem_be_o    = lane_q[1] ? BeHalfHi : BeHalfLo;
          dmem_wdata_o = {2{regb_q[15:0]}};
        end
        default: begin
          dmem_be_o    = BeWord;
          dmem_wdata_o = regb_q;
        end
      endcase
    end
  end

  always_comb begin
    case (state_q)
      StIdle:         mem_stall_o = mem_op;
      StReq, StWait:  mem_stall_o = 1'b1;
      default:        mem_stall_o = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    word_addr_d  = word_addr_q;
    regb_d       = regb_q;
    funct3_d     = funct3_q;
    lane_d       = lane_q;
    load_d       = load_q;
    rsp_pend_d   = rsp_pend_q;
    valid_d      = 1'b0;
    result_d     = result_q;
    bus_err_d    = 1'b0;
    misaligned_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (mem_op) begin
          word_addr_d = ex_mem_alu_result_i[31:2];
          regb_d      = ex_mem_regb_i;
          funct3_d    = ex_mem_funct3_i;
          lane_d      = lane_in;
          load_d      = ex_mem_rd_mem_i;
          cnt_d       = '0;
          rsp_pend_d  = 1'b0;
          if (misalign_in) begin
            state_d      = StDone;
            valid_d      = 1'b1;
            misaligned_d = 1'b1;
            result_d     = '0;
          end else begin
            state_d = StReq;
          end
        end else if (ex_mem_valid_inst_i) begin
          valid_d  = 1'b1;
          result_d = ex_mem_alu_result_i;
        end
      end
      StReq: begin
        // Stores have nothing to write back, so they complete with a zero result.
        if (dmem_gnt_i && !load_q) begin
          state_d  = StDone;
          valid_d  = 1'b1;
          result_d = '0;
        end else if (timeout_hit) begin
          state_d   = StDone;
          valid_d   = 1'b1;
          bus_err_d = 1'b1;
          result_d  = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
          if (dmem_gnt_i) begin
            state_d = StWait;
            // Response arriving with the grant is parked and retired from WAIT.
            if (dmem_rvalid_i) begin
              rsp_pend_d = 1'b1;
              result_d   = load_data;
            end
          end
        end
      end
      StWait: begin
        if (rsp_pend_q || dmem_rvalid_i) begin
          state_d = StDone;
          valid_d = 1'b1;
          if (!rsp_pend_q) result_d = load_data;
        end else if (timeout_hit) begin
          state_d   = StDone;
          valid_d   = 1'b1;
          bus_err_d = 1'b1;
          result_d  = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      word_addr_q  <= '0;
      regb_q       <= '0;
      funct3_q     <= '0;
      lane_q       <= '0;
      load_q       <= 1'b0;
      rsp_pend_q   <= 1'b0;
      valid_q      <= 1'b0;
      result_q     <= '0;
      bus_err_q    <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      word_addr_q  <= word_addr_d;
      regb_q       <= regb_d;
      funct3_q     <= funct3_d;
      lane_q       <= lane_d;
      load_q       <= load_d;
      rsp_pend_q   <= rsp_pend_d;
      valid_q      <= valid_d;
      result_q     <= result_d;
      bus_err_q    <= bus_err_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign mem_valid_o      = valid_q;
  assign mem_result_o     = result_q;
  assign mem_bus_err_o    = bus_err_q;
  assign mem_misaligned_o = misaligned_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, random operations
// against a transaction-level model, and hand-written reset sequences.
module tb_mem_stage;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_rd, ex_wr;
  logic [31:0] ex_alu, ex_regb;
  logic [2:0]  ex_f3;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stall, valid, bus_err, misal;
  logic [31:0] result;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(TO)) u_dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .ex_mem_valid_inst_i (ex_valid),
    .ex_mem_alu_result_i (ex_alu),
    .ex_mem_regb_i       (ex_regb),
    .ex_mem_rd_mem_i     (ex_rd),
    .ex_mem_wr_mem_i     (ex_wr),
    .ex_mem_funct3_i     (ex_f3),
    .dmem_req_o          (dmem_req),
    .dmem_we_o           (dmem_we),
    .dmem_addr_o         (dmem_addr),
    .dmem_wdata_o        (dmem_wdata),
    .dmem_be_o           (dmem_be),
    .dmem_gnt_i          (dmem_gnt),
    .dmem_rvalid_i       (dmem_rvalid),
    .dmem_rdata_i        (dmem_rdata),
    .mem_stall_o         (stall),
    .mem_valid_o         (valid),
    .mem_result_o        (result),
    .mem_bus_err_o       (bus_err),
    .mem_misaligned_o    (misal)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        vld, rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, regb, rdata;
    int          gdly, rdly;
    logic [31:0] exp_res;
    logic        exp_err, exp_mis;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    ex_valid = 1'b0; ex_rd = 1'b0; ex_wr = 1'b0;
    ex_alu = '0; ex_regb = '0; ex_f3 = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
  endtask

  function automatic vec_t mk(input logic vld, rd, wr, input logic [2:0] f3,
                              input logic [31:0] addr, regb, rdata, input int g, r,
                              input logic [31:0] res, input logic err, mis,
                              input logic [3:0] be, input logic [31:0] wd);
    vec_t v;
    v.vld = vld; v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.regb = regb;
    v.rdata = rdata; v.gdly = g; v.rdly = r; v.exp_res = res; v.exp_err = err;
    v.exp_mis = mis; v.exp_be = be; v.exp_wdata = wd;
    return v;
  endfunction

  // Transaction-level reference: outcome of one instruction from the access rules.
  function automatic vec_t model(input vec_t v);
    int size, lo, lane, cyc;
    logic [31:0] raw;
    v.exp_err = 1'b0; v.exp_mis = 1'b0; v.exp_be = '0; v.exp_wdata = '0;
    if (!(v.vld && (v.rd || v.wr))) begin
      v.exp_res = v.addr;
      return v;
    end
    case (v.f3)
      3'b000, 3'b100: size = 1;
      3'b001, 3'b101: size = 2;
      default:        size = 4;
    endcase
    lo   = int'(v.addr[1:0]);
    lane = lo - (lo % size);
`ifdef MEM_MISALIGN_CHECK_EN
    v.exp_mis = ((lo % size) != 0);
`endif
    v.exp_be    = 4'(((1 << size) - 1) << lane);
    v.exp_wdata = (size == 1) ? 32'(v.regb[7:0]) * 32'h0101_0101 :
                  (size == 2) ? 32'(v.regb[15:0]) * 32'h0001_0001 : v.regb;
    raw = v.rdata >> (8 * lane);
    if (size == 1) begin
      raw = raw & 32'hFF;
      if (!v.f3[2] && raw[7]) raw = raw | 32'hFFFF_FF00;
    end else if (size == 2) begin
      raw = raw & 32'hFFFF;
      if (!v.f3[2] && raw[15]) raw = raw | 32'hFFFF_0000;
    end
    cyc = v.rd ? v.gdly + 1 + ((v.rdly < 1) ? 1 : v.rdly) : v.gdly + 1;
    v.exp_err = !v.exp_mis && (cyc > TO);
    v.exp_res = (v.exp_mis || v.exp_err || !v.rd) ? 32'h0 : raw;
    return v;
  endfunction

  task automatic do_op(input vec_t v, input string tag);
    logic is_mem, load;
    int   c, exp_cyc, cyc;
    is_mem = v.vld & (v.rd | v.wr);
    load   = v.rd;
    ex_valid = v.vld; ex_rd = v.rd; ex_wr = v.wr; ex_f3 = v.f3;
    ex_alu = v.addr; ex_regb = v.regb; dmem_rdata = v.rdata;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    #1;
    chk({tag, ".stall_idle"}, stall, is_mem);
    if (!is_mem) begin
      tick();
      #1;
      chk({tag, ".valid"}, valid, v.vld);
      if (v.vld) chk({tag, ".result"}, result, v.exp_res);
      chk({tag, ".stall"}, stall, 1'b0);
      return;
    end
    if (v.exp_mis) begin
      chk({tag, ".no_req"}, dmem_req, 1'b0);
      tick();
      #1;
      chk({tag, ".valid"}, valid, 1'b1);
      chk({tag, ".misaligned"}, misal, 1'b1);
      chk({tag, ".result"}, result, 32'h0);
      chk({tag, ".no_req_done"}, dmem_req, 1'b0);
      drive_idle();
      tick();
      #1;
      chk({tag, ".valid_pulse"}, valid, 1'b0);
      return;
    end
    c       = load ? v.gdly + 1 + ((v.rdly < 1) ? 1 : v.rdly) : v.gdly + 1;
    exp_cyc = v.exp_err ? TO + 1 : c + 1;
    cyc     = 0;
    while (cyc < TO + 10) begin
      tick();
      cyc++;
      dmem_gnt    = (cyc == v.gdly + 1);
      dmem_rvalid = load && (cyc == v.gdly + 1 + v.rdly);
      #1;
      if (valid) break;
      chk({tag, ".stall_busy"}, stall, 1'b1);
      chk({tag, ".req"}, dmem_req, (cyc <= v.gdly + 1));
      if (dmem_req) begin
        chk({tag, ".addr"}, dmem_addr, {v.addr[31:2], 2'b00});
        chk({tag, ".we"}, dmem_we, !load);
        if (!load) begin
          chk({tag, ".be"}, dmem_be, v.exp_be);
          chk({tag, ".wdata"}, dmem_wdata, v.exp_wdata);
        end
      end
    end
    chk({tag, ".valid"}, valid, 1'b1);
    chk({tag, ".latency"}, cyc, exp_cyc);
    chk({tag, ".bus_err"}, bus_err, v.exp_err);
    chk({tag, ".misaligned"}, misal, 1'b0);
    if (load || v.exp_err) chk({tag, ".result"}, result, v.exp_res);
    chk({tag, ".stall_done"}, stall, 1'b0);
    chk({tag, ".req_done"}, dmem_req, 1'b0);
    drive_idle();
    tick();
    #1;
    chk({tag, ".valid_pulse"}, valid, 1'b0);
  endtask

  vec_t tbl[18];
  vec_t rv;
  int   k;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(1, 0, 0, 3'b000, 32'h1234, 0, 0, 0, 0, 32'h1234, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 3'b010, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 1, 0, 3'b000, 32'h103, 0, 32'h80FF_0000, 0, 1, 32'hFFFF_FF80, 0, 0, 0, 0);
    tbl[3]  = mk(1, 0, 1, 3'b001, 32'h202, 32'hAAAA_BEEF, 0, 0, 0, 0, 0, 0, 4'b1100,
                 32'hBEEF_BEEF);
    tbl[4]  = mk(1, 1, 0, 3'b010, 32'h400, 0, 32'hCAFE_F00D, 5, 2, 32'hCAFE_F00D, 0, 0, 0, 0);
    tbl[5]  = mk(1, 1, 0, 3'b001, 32'h102, 0, 32'h8001_1234, 1, 0, 32'hFFFF_8001, 0, 0, 0, 0);
    tbl[6]  = mk(1, 1, 0, 3'b101, 32'h102, 0, 32'h8001_1234, 1, 0, 32'h0000_8001, 0, 0, 0, 0);
    tbl[7]  = mk(1, 1, 0, 3'b100, 32'h101, 0, 32'h0000_A500, 0, 3, 32'h0000_00A5, 0, 0, 0, 0);
    tbl[8]  = mk(1, 0, 1, 3'b000, 32'h301, 32'h1234_567E, 0, 1, 0, 0, 0, 0, 4'b0010,
                 32'h7E7E_7E7E);
    tbl[9]  = mk(1, 0, 1, 3'b010, 32'h304, 32'hDEAD_BEEF, 0, 2, 0, 0, 0, 0, 4'b1111,
                 32'hDEAD_BEEF);
    tbl[10] = mk(1, 1, 0, 3'b010, 32'h500, 0, 32'h1111_1111, 20, 0, 0, 1, 0, 0, 0);
    tbl[11] = mk(1, 0, 1, 3'b010, 32'h504, 32'h5, 0, 9, 0, 0, 1, 0, 4'b1111, 32'h5);
    tbl[12] = mk(1, 1, 0, 3'b011, 32'h600, 0, 32'h0102_0304, 0, 1, 32'h0102_0304, 0, 0, 0, 0);
    tbl[13] = mk(1, 1, 1, 3'b010, 32'h700, 32'h9, 32'h55AA_55AA, 0, 1, 32'h55AA_55AA, 0, 0, 0,
                 0);
`ifdef MEM_MISALIGN_CHECK_EN
    tbl[14] = mk(1, 1, 0, 3'b010, 32'h101, 0, 32'h1122_3344, 0, 1, 0, 0, 1, 0, 0);
    tbl[15] = mk(1, 0, 1, 3'b001, 32'h203, 32'hCDEF, 0, 0, 0, 0, 0, 1, 0, 0);
`else
    tbl[14] = mk(1, 1, 0, 3'b010, 32'h101, 0, 32'h1122_3344, 0, 1, 32'h1122_3344, 0, 0, 0, 0);
    tbl[15] = mk(1, 0, 1, 3'b001, 32'h203, 32'hCDEF, 0, 0, 0, 0, 0, 0, 4'b1100, 32'hCDEF_CDEF);
`endif
    tbl[16] = mk(1, 0, 1, 3'b010, 32'h800, 32'h77, 0, 7, 0, 0, 0, 0, 4'b1111, 32'h77);
    tbl[17] = mk(1, 1, 0, 3'b010, 32'h804, 0, 32'h2222_2222, 7, 0, 0, 1, 0, 0, 0);

    rst_n = 1'b0;
    drive_idle();
    #3;
    chk("reset.valid", valid, 1'b0);
    chk("reset.result", result, 32'h0);
    chk("reset.bus_err", bus_err, 1'b0);
    chk("reset.misaligned", misal, 1'b0);
    chk("reset.stall", stall, 1'b0);
    chk("reset.req", dmem_req, 1'b0);
    chk("reset.we", dmem_we, 1'b0);
    chk("reset.addr", dmem_addr, 32'h0);
    chk("reset.wdata", dmem_wdata, 32'h0);
    chk("reset.be", dmem_be, 4'h0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 18; i++) do_op(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 60; i++) begin
      rv.vld   = ($urandom % 8) != 0;
      k        = int'($urandom % 4);
      rv.rd    = (k == 1) || (k == 3);
      rv.wr    = (k == 2) || (k == 3);
      rv.f3    = 3'($urandom % 8);
      rv.addr  = $urandom;
      rv.regb  = $urandom;
      rv.rdata = $urandom;
      rv.gdly  = (($urandom % 6) == 0) ? 9 + int'($urandom % 3) : int'($urandom % 4);
      rv.rdly  = int'($urandom % 4);
      rv = model(rv);
      do_op(rv, $sformatf("rnd%0d", i));
    end

    // Reset while a request is outstanding must drop it at once.
    ex_valid = 1'b1; ex_alu = 32'hFFFF_0000;
    tick();
    ex_rd = 1'b1; ex_f3 = 3'b010; ex_alu = 32'h900;
    #1;
    chk("rst_req.prior_result", result, 32'hFFFF_0000);
    tick();
    #1;
    chk("rst_req.req_before", dmem_req, 1'b1);
    rst_n = 1'b0;
    drive_idle();
    #1;
    chk("rst_req.req", dmem_req, 1'b0);
    chk("rst_req.addr", dmem_addr, 32'h0);
    chk("rst_req.stall", stall, 1'b0);
    chk("rst_req.result", result, 32'h0);
    tick();
    rst_n = 1'b1;

    // Reset in WAIT; a late response afterwards must be ignored.
    ex_valid = 1'b1; ex_rd = 1'b1; ex_f3 = 3'b010; ex_alu = 32'hA00;
    #1;
    tick();
    dmem_gnt = 1'b1;
    #1;
    tick();
    dmem_gnt = 1'b0;
    #1;
    chk("rst_wait.stall_before", stall, 1'b1);
    chk("rst_wait.req_before", dmem_req, 1'b0);
    rst_n = 1'b0;
    drive_idle();
    #1;
    chk("rst_wait.stall", stall, 1'b0);
    chk("rst_wait.valid", valid, 1'b0);
    tick();
    rst_n = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1357_9BDF;
    #1;
    tick();
    dmem_rvalid = 1'b0;
    #1;
    chk("rst_wait.late_valid", valid, 1'b0);
    chk("rst_wait.late_stall", stall, 1'b0);
    chk("rst_wait.late_result", result, 32'h0);
    tick();
    #1;
    chk("rst_wait.late_valid2", valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
